// File: rtl/pkt_dedup.sv
// Streaming adjacent-duplicate remover for sorted packets. One word is held back so
// that the last unique word of a packet can carry end-of-packet; length is reported per packet.
module pkt_dedup #(
  parameter int DWIDTH      = 8,
  parameter int MAX_PKT_LEN = 1024,
  localparam int LEN_W      = $clog2(MAX_PKT_LEN + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DWIDTH-1:0] snk_data_i,
  input  logic              snk_startofpacket_i,
  input  logic              snk_endofpacket_i,
  input  logic              snk_valid_i,
  output logic              snk_ready_o,
  output logic [DWIDTH-1:0] src_data_o,
  output logic              src_startofpacket_o,
  output logic              src_endofpacket_o,
  output logic              src_valid_o,
  input  logic              src_ready_i,
  output logic [LEN_W-1:0]  len_o,
  output logic              len_valid_o,
  output logic              err_o
);

  typedef enum logic [1:0] {IDLE, BODY, FLUSH} state_t;

  state_t              state, state_nxt;
  logic [DWIDTH-1:0]   hold_data, hold_nxt;
  logic                first_pend, first_nxt;
  logic [LEN_W-1:0]    out_cnt;

  logic                emit, emit_sop, emit_eop;
  logic [DWIDTH-1:0]   emit_data;
  logic                err_nxt, abort;
  logic                out_free, acc, taken, restart;

  assign out_free    = !src_valid_o || src_ready_i;
  assign snk_ready_o = (state != FLUSH) && out_free;
  assign acc         = snk_valid_i && snk_ready_o;
  assign taken       = src_valid_o && src_ready_i;
  // A sop beat always starts a fresh packet, whether we were idle or mid-packet.
  assign restart     = (state == IDLE) || snk_startofpacket_i;

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_data;
    first_nxt = first_pend;
    emit      = 1'b0;
    emit_data = hold_data;
    emit_sop  = 1'b0;
    emit_eop  = 1'b0;
    err_nxt   = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE, BODY: begin
        if (acc) begin
          if (state == BODY && snk_startofpacket_i) begin
            abort   = 1'b1;
            err_nxt = 1'b1;
          end
          if (restart) begin
            if (!snk_startofpacket_i) begin
              err_nxt = 1'b1;
            end else if (snk_endofpacket_i) begin
              emit      = 1'b1;
              emit_data = snk_data_i;
              emit_sop  = 1'b1;
              emit_eop  = 1'b1;
              state_nxt = IDLE;
            end else begin
              hold_nxt  = snk_data_i;
              first_nxt = 1'b1;
              state_nxt = BODY;
            end
          end else if (snk_data_i == hold_data) begin
            if (snk_endofpacket_i) begin
              emit      = 1'b1;
              emit_sop  = first_pend;
              emit_eop  = 1'b1;
              state_nxt = IDLE;
            end
          end else begin
            emit      = 1'b1;
            emit_sop  = first_pend;
            hold_nxt  = snk_data_i;
            first_nxt = 1'b0;
            if (snk_endofpacket_i) state_nxt = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (out_free) begin
          emit      = 1'b1;
          emit_eop  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      hold_data  <= '0;
      first_pend <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      state      <= state_nxt;
      hold_data  <= hold_nxt;
      first_pend <= first_nxt;
      err_o      <= err_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_data_o          <= '0;
      src_startofpacket_o <= 1'b0;
      src_endofpacket_o   <= 1'b0;
      src_valid_o         <= 1'b0;
    end else if (emit) begin
      src_data_o          <= emit_data;
      src_startofpacket_o <= emit_sop;
      src_endofpacket_o   <= emit_eop;
      src_valid_o         <= 1'b1;
    end else if (taken) begin
      src_valid_o         <= 1'b0;
    end
  end

  // An abort clears the count even if a beat of the dead packet leaves this cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_cnt     <= '0;
      len_o       <= '0;
      len_valid_o <= 1'b0;
    end else begin
      len_valid_o <= 1'b0;
      if (taken) begin
        if (src_endofpacket_o) begin
          len_o       <= out_cnt + 1'b1;
          len_valid_o <= 1'b1;
          out_cnt     <= '0;
        end else begin
          out_cnt     <= out_cnt + 1'b1;
        end
      end
      if (abort) out_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_pkt_dedup.sv
// Directed bench for pkt_dedup: a per-cycle vector table plus hand-run sequences
// for backpressure and mid-packet reset.
module tb_pkt_dedup;
  localparam int DW   = 8;
  localparam int MAXL = 1024;
  localparam int LW   = $clog2(MAXL + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] snk_data = '0;
  logic          snk_sop = 1'b0, snk_eop = 1'b0, snk_valid = 1'b0;
  logic          snk_ready;
  logic [DW-1:0] src_data;
  logic          src_sop, src_eop, src_valid;
  logic          src_ready = 1'b1;
  logic [LW-1:0] len;
  logic          len_valid, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pkt_dedup #(.DWIDTH(DW), .MAX_PKT_LEN(MAXL)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .snk_data_i(snk_data), .snk_startofpacket_i(snk_sop), .snk_endofpacket_i(snk_eop),
    .snk_valid_i(snk_valid), .snk_ready_o(snk_ready),
    .src_data_o(src_data), .src_startofpacket_o(src_sop), .src_endofpacket_o(src_eop),
    .src_valid_o(src_valid), .src_ready_i(src_ready),
    .len_o(len), .len_valid_o(len_valid), .err_o(err)
  );

  typedef struct {
    logic v, s, e; logic [7:0] d; logic r;
    logic xrdy, xv; logic [7:0] xd; logic xs, xe, xlv; logic [10:0] xlen; logic xerr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic s, logic e, logic [7:0] d, logic r,
                              logic xrdy, logic xv, logic [7:0] xd, logic xs, logic xe,
                              logic xlv, logic [10:0] xlen, logic xerr);
    vec_t t;
    t.v = v; t.s = s; t.e = e; t.d = d; t.r = r;
    t.xrdy = xrdy; t.xv = xv; t.xd = xd; t.xs = xs; t.xe = xe;
    t.xlv = xlv; t.xlen = xlen; t.xerr = xerr;
    return t;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Packet driver / output collector shared by the multi-cycle sequences.
  logic [7:0] pin[$];
  logic [9:0] pout[$];
  int         got_len;
  bit         got_lv;
  int         stab_err;

  task automatic run_pkt(input bit toggle);
    int idx = 0;
    int cyc = 0;
    bit done = 0;
    bit prev_stall = 0;
    logic [9:0] prev = '0;
    pout.delete();
    got_lv = 0; got_len = 0; stab_err = 0;
    while (!done && cyc < 300) begin
      src_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
      if (idx < pin.size()) begin
        snk_valid = 1'b1; snk_data = pin[idx];
        snk_sop = (idx == 0); snk_eop = (idx == pin.size() - 1);
      end else begin
        snk_valid = 1'b0; snk_sop = 1'b0; snk_eop = 1'b0;
      end
      #1;
      if (prev_stall && (!src_valid || {src_sop, src_eop, src_data} != prev)) stab_err++;
      prev       = {src_sop, src_eop, src_data};
      prev_stall = src_valid && !src_ready;
      if (src_valid && src_ready) pout.push_back({src_sop, src_eop, src_data});
      if (len_valid) begin got_lv = 1; got_len = int'(len); done = 1; end
      if (snk_valid && snk_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    snk_valid = 1'b0; snk_sop = 1'b0; snk_eop = 1'b0; src_ready = 1'b1;
  endtask

  initial begin
    // pkt 1,1,3,3,3,7 -> 1,3,7 with one flush cycle
    tbl.push_back(mk(1,1,0,8'h01,1, 1,0,8'h00,0,0, 0,11'd0,0));
    tbl.push_back(mk(1,0,0,8'h01,1, 1,0,8'h00,0,0, 0,11'd0,0));
    tbl.push_back(mk(1,0,0,8'h03,1, 1,0,8'h00,0,0, 0,11'd0,0));
    tbl.push_back(mk(1,0,0,8'h03,1, 1,1,8'h01,1,0, 0,11'd0,0));
    tbl.push_back(mk(1,0,0,8'h03,1, 1,0,8'h00,0,0, 0,11'd0,0));
    tbl.push_back(mk(1,0,1,8'h07,1, 1,0,8'h00,0,0, 0,11'd0,0));
    tbl.push_back(mk(0,0,0,8'h00,1, 0,1,8'h03,0,0, 0,11'd0,0));
    tbl.push_back(mk(0,0,0,8'h00,1, 1,1,8'h07,0,1, 0,11'd0,0));
    tbl.push_back(mk(0,0,0,8'h00,1, 1,0,8'h00,0,0, 1,11'd3,0));
    // pkt 5,5,5,5 -> single 5 sop+eop, no flush
    tbl.push_back(mk(1,1,0,8'h05,1, 1,0,8'h00,0,0, 0,11'd0,0));
    tbl.push_back(mk(1,0,0,8'h05,1, 1,0,8'h00,0,0, 0,11'd0,0));
    tbl.push_back(mk(1,0,0,8'h05,1, 1,0,8'h00,0,0, 0,11'd0,0));
    tbl.push_back(mk(1,0,1,8'h05,1, 1,0,8'h00,0,0, 0,11'd0,0));
    tbl.push_back(mk(0,0,0,8'h00,1, 1,1,8'h05,1,1, 0,11'd0,0));
    // single beat 0xAA
    tbl.push_back(mk(1,1,1,8'hAA,1, 1,0,8'h00,0,0, 1,11'd1,0));
    tbl.push_back(mk(0,0,0,8'h00,1, 1,1,8'hAA,1,1, 0,11'd0,0));
    tbl.push_back(mk(0,0,0,8'h00,1, 1,0,8'h00,0,0, 1,11'd1,0));
    // stray beat in IDLE, then packet 2,4 aborted by sop 0x20, packet 0x20,0x21
    tbl.push_back(mk(1,0,0,8'h11,1, 1,0,8'h00,0,0, 0,11'd0,0));
    tbl.push_back(mk(1,1,0,8'h02,1, 1,0,8'h00,0,0, 0,11'd0,1));
    tbl.push_back(mk(1,0,0,8'h04,1, 1,0,8'h00,0,0, 0,11'd0,0));
    tbl.push_back(mk(1,1,0,8'h20,1, 1,1,8'h02,1,0, 0,11'd0,0));
    tbl.push_back(mk(1,0,1,8'h21,1, 1,0,8'h00,0,0, 0,11'd0,1));
    tbl.push_back(mk(0,0,0,8'h00,1, 0,1,8'h20,1,0, 0,11'd0,0));
    tbl.push_back(mk(0,0,0,8'h00,1, 1,1,8'h21,0,1, 0,11'd0,0));
    tbl.push_back(mk(0,0,0,8'h00,1, 1,0,8'h00,0,0, 1,11'd2,0));

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", src_valid, 0);
    chk("rst_len_valid", len_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", snk_ready, 1);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      vec_t t;
      logic [7:0]  ad;
      logic        as_, ae;
      logic [10:0] al;
      t = tbl[i];
      snk_valid = t.v; snk_sop = t.s; snk_eop = t.e; snk_data = t.d; src_ready = t.r;
      #1;
      ad  = src_valid ? src_data : 8'h00;
      as_ = src_valid ? src_sop : 1'b0;
      ae  = src_valid ? src_eop : 1'b0;
      al  = len_valid ? len : 11'd0;
      checks++;
      if ({snk_ready, src_valid, ad, as_, ae, len_valid, al, err} !==
          {t.xrdy, t.xv, t.xd, t.xs, t.xe, t.xlv, t.xlen, t.xerr}) begin
        errors++;
        $display("FAIL vec%0d got rdy=%b v=%b d=%h s=%b e=%b lv=%b len=%0d err=%b expected rdy=%b v=%b d=%h s=%b e=%b lv=%b len=%0d err=%b",
                 i, snk_ready, src_valid, ad, as_, ae, len_valid, al, err,
                 t.xrdy, t.xv, t.xd, t.xs, t.xe, t.xlv, t.xlen, t.xerr);
      end
      @(posedge clk); #1;
    end
    snk_valid = 1'b0; snk_sop = 1'b0; snk_eop = 1'b0; src_ready = 1'b1;

    // 0..9 distinct under toggling backpressure
    pin.delete();
    for (int i = 0; i < 10; i++) pin.push_back(8'(i));
    run_pkt(1'b1);
    chk("tog_len_seen", got_lv, 1);
    chk("tog_len", got_len, 10);
    chk("tog_count", pout.size(), 10);
    chk("tog_stable", stab_err, 0);
    for (int i = 0; i < 10; i++)
      chk($sformatf("tog_beat%0d", i), (i < pout.size()) ? int'(pout[i]) : -1,
          int'({(i == 0), (i == 9), 8'(i)}));

    // reset after 3 beats of 1,2,3
    for (int i = 1; i <= 3; i++) begin
      snk_valid = 1'b1; snk_sop = (i == 1); snk_eop = 1'b0; snk_data = 8'(i);
      @(posedge clk); #1;
    end
    snk_valid = 1'b0; snk_sop = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", src_valid, 0);
    chk("mid_rst_data", src_data, 0);
    chk("mid_rst_sop_eop", {src_sop, src_eop}, 0);
    chk("mid_rst_len", {len_valid, len}, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_ready", snk_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    pin.delete();
    pin.push_back(8'h09); pin.push_back(8'h09); pin.push_back(8'h08);
    run_pkt(1'b0);
    chk("post_rst_len_seen", got_lv, 1);
    chk("post_rst_len", got_len, 2);
    chk("post_rst_count", pout.size(), 2);
    chk("post_rst_beat0", (pout.size() > 0) ? int'(pout[0]) : -1, int'({1'b1, 1'b0, 8'h09}));
    chk("post_rst_beat1", (pout.size() > 1) ? int'(pout[1]) : -1, int'({1'b0, 1'b1, 8'h08}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pkt_dedup.md
# pkt_dedup

Streaming packet stage placed directly downstream of the packet sorter: consumes sorted packets on an Avalon-ST-style sink and re-emits each packet with adjacent duplicate words removed (e.g. 1,1,3,3,3,7 -> 1,3,7). Holds one word internally so the last unique word can carry end-of-packet. On every emitted end-of-packet it reports the output packet length.

## Interface
- DWIDTH, 8, data word width
- MAX_PKT_LEN, 1024, maximum input packet length in words; LEN_W = $clog2(MAX_PKT_LEN+1)
- clk_i  in  1  single clock, all logic on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- snk_data_i  in  DWIDTH  input word
- snk_startofpacket_i  in  1  first word of input packet
- snk_endofpacket_i  in  1  last word of input packet
- snk_valid_i  in  1  input word valid
- snk_ready_o  out  1  block accepts input this cycle (combinational)
- src_data_o  out  DWIDTH  output word (registered)
- src_startofpacket_o  out  1  first word of output packet
- src_endofpacket_o  out  1  last word of output packet
- src_valid_o  out  1  output word valid
- src_ready_i  in  1  downstream accepts output this cycle
- len_o  out  LEN_W  word count of the packet just completed on the source side
- len_valid_o  out  1  one-cycle pulse qualifying len_o
- err_o  out  1  one-cycle pulse on protocol error

## Operation
- Sink beat accepted when snk_valid_i && snk_ready_o; source beat taken when src_valid_o && src_ready_i.
- Internal: hold register (hold_data), output register (src_*), FSM states IDLE, BODY, FLUSH; first_pend flag (next emitted word gets sop); out_cnt (LEN_W bits).
- snk_ready_o = (state != FLUSH) && (!src_valid_o || src_ready_i).
- IDLE: accepted beat without sop -> dropped, err_o pulse. Beat with sop and eop -> loaded into output register with sop=1, eop=1; stay IDLE. Beat with sop only -> hold_data <= data, first_pend <= 1, go BODY.
- BODY, accepted beat with sop -> previous packet aborted: hold discarded, out_cnt cleared, err_o pulse, then handled as in IDLE.
- BODY, no eop, data == hold_data -> dropped (duplicate).
- BODY, no eop, data != hold_data -> emit hold_data (sop = first_pend, eop=0), hold_data <= data, first_pend <= 0.
- BODY, eop, data == hold_data -> emit hold_data with eop=1, sop = first_pend; go IDLE.
- BODY, eop, data != hold_data -> emit hold_data (eop=0), hold_data <= data, go FLUSH.
- FLUSH: sink stalled; when output register free (!src_valid_o || src_ready_i) emit hold_data with eop=1, sop=0; go IDLE.
- "Emit" = load output register and set src_valid_o; src_valid_o clears when taken and not reloaded the same cycle.
- out_cnt increments on each source beat taken; on taken beat with eop: len_o <= out_cnt+1, len_valid_o pulses, out_cnt <= 0.
- Comparison is full DWIDTH equality; no arithmetic on data. out_cnt never exceeds MAX_PKT_LEN (no wrap needed).

## Timing
- Reset (rst_ni low, asynchronous): state IDLE, src_valid_o, src_startofpacket_o, src_endofpacket_o, len_valid_o, err_o = 0; src_data_o, len_o, out_cnt, hold_data = 0; snk_ready_o = 1 one delta after reset (combinational). Reset mid-packet discards all held/partial data; no eop emitted.
- Latency: a unique word appears on src one cycle after the next differing word (or eop) is accepted. Single-beat packet: one cycle.
- Throughput: one beat/cycle with src_ready_i held high; one extra cycle per packet whose last word differs from its predecessor (FLUSH).
- Output holds src_data_o/sop/eop/valid stable while src_valid_o && !src_ready_i.
- len_valid_o asserts the cycle after the eop beat is taken; err_o the cycle after the offending beat is accepted.
- Back-to-back packets: sop of next packet may be accepted in the cycle FLUSH/IDLE returns and the output register is free.

## Test plan
- Packet 1,1,3,3,3,7 (sop on 1, eop on 7), src_ready_i=1 -> output 1(sop),3,7(eop); len_o=3 pulse; one FLUSH cycle with snk_ready_o=0.
- Packet 5,5,5,5 -> single output 5 with sop=1 and eop=1; len_o=1; no FLUSH.
- Single beat 0xAA with sop+eop -> 0xAA sop+eop one cycle later; len_o=1.
- Packet 0..9 all distinct, src_ready_i toggling 1/0 each cycle -> 0..9 in order, data stable while stalled, no loss or duplication, len_o=10.
- Beat without sop in IDLE, then sop during BODY of a packet 2,4 -> err_o pulses twice; aborted packet produces no eop; new packet output correct.
- Assert rst_ni low mid-packet (after 3 beats) -> all outputs 0 immediately, snk_ready_o=1; next packet 9,9,8 -> 9(sop),8(eop), len_o=2.
